raw_scoreboard: RTL and testbench

//  RAW/WAW hazard detector feeding IDU's conflict-detection interface: consumes reg1_read/reg2_read/raddr1/raddr2,

---
 rtl/raw_scoreboard_pkg.sv | 17 +
 rtl/raw_scoreboard_if.sv | 32 +++
 rtl/raw_pend_counter.sv | 47 ++++
 rtl/raw_scoreboard.sv | 75 +++++++
 tb/tb_raw_scoreboard.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/raw_scoreboard_pkg.sv
// Shared constants and types for the RAW/WAW hazard scoreboard.
//   NR_REG  : architectural registers tracked (RV32E, x0 never tracked)
//   CNT_W   : width of each pending-write counter
//   RF_AW   : register index width; address bit [4] is ignored
package raw_scoreboard_pkg;

  localparam int unsigned NR_REG = 16;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned RF_AW  = 4;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RF_AW-1:0] reg_idx_t;

  // Largest representable in-flight write count per register.
  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/raw_scoreboard_if.sv
// IDU/WBU <-> scoreboard signal bundle.
//   master : IDU/WBU side, drives decode/issue/retire info, receives RAW_check/idle/err
//   slave  : scoreboard side
interface raw_scoreboard_if;

  logic       processing;
  logic       reg1_read;
  logic       reg2_read;
  logic [4:0] raddr1;
  logic [4:0] raddr2;
  logic       dec_regwrite;
  logic [4:0] dec_rd;
  logic       issue;
  logic       wb_regwrite;
  logic [4:0] wb_addr;
  logic       RAW_check;
  logic       idle;
  logic       err;

  modport master (
    output processing, reg1_read, reg2_read, raddr1, raddr2,
    output dec_regwrite, dec_rd, issue, wb_regwrite, wb_addr,
    input  RAW_check, idle, err
  );

  modport slave (
    input  processing, reg1_read, reg2_read, raddr1, raddr2,
    input  dec_regwrite, dec_rd, issue, wb_regwrite, wb_addr,
    output RAW_check, idle, err
  );

endinterface

// File: rtl/raw_pend_counter.sv
// One pending-write counter for a single architectural register.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   inc       : a write to this register was issued this cycle
//   dec       : a write to this register retired this cycle
//   zero      : counter is zero (no pending write)
//   full      : counter is at CNT_MAX
//   next_zero : next-state counter is zero
//   err       : this cycle's update was illegal (overflow or underflow)
module raw_pend_counter
  import raw_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full,
  output logic next_zero,
  output logic err
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    // Simultaneous inc and dec cancel out, even at the limits.
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) err = 1'b1;  // saturate
      else                  cnt_d = cnt_q + cnt_t'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) err = 1'b1;       // hold at zero
      else             cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero      = (cnt_q == '0);
  assign full      = (cnt_q == CNT_MAX);
  assign next_zero = (cnt_d == '0);

endmodule

// File: rtl/raw_scoreboard.sv
// RAW/WAW hazard scoreboard between IDU and WBU.
// Tracks in-flight writes per register; stalls IDU (RAW_check) when a source has a pending
// write or the destination counter is full. Reports pipeline drain (idle) and a sticky err
// for illegal counter updates.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   sb       : raw_scoreboard_if.slave bundle (decode/issue/retire in, RAW_check/idle/err out)
module raw_scoreboard
  import raw_scoreboard_pkg::*;
(
  input logic              clk,
  input logic              rst,
  raw_scoreboard_if.slave  sb
);

  reg_idx_t rs1, rs2, rd, wb_rd;
  logic     unused_hi_bits;

  assign rs1   = sb.raddr1[RF_AW-1:0];
  assign rs2   = sb.raddr2[RF_AW-1:0];
  assign rd    = sb.dec_rd[RF_AW-1:0];
  assign wb_rd = sb.wb_addr[RF_AW-1:0];
  // Bit [4] of every address is deliberately ignored (16-entry regfile).
  assign unused_hi_bits = sb.raddr1[4] ^ sb.raddr2[4] ^ sb.dec_rd[4] ^ sb.wb_addr[4];

  logic [NR_REG-1:0] zero_vec, full_vec, next_zero_vec, err_vec;

  // x0 is never tracked: its slot reads as permanently empty.
  assign zero_vec[0]      = 1'b1;
  assign full_vec[0]      = 1'b0;
  assign next_zero_vec[0] = 1'b1;
  assign err_vec[0]       = 1'b0;

  for (genvar i = 1; i < NR_REG; i++) begin : g_cnt
    logic inc, dec;
    assign inc = sb.issue & sb.dec_regwrite & (rd == reg_idx_t'(i));
    assign dec = sb.wb_regwrite & (wb_rd == reg_idx_t'(i));

    raw_pend_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc),
      .dec       (dec),
      .zero      (zero_vec[i]),
      .full      (full_vec[i]),
      .next_zero (next_zero_vec[i]),
      .err       (err_vec[i])
    );
  end

  // Zero/full flags of slot 0 already mask x0, so no explicit !=0 compare is needed.
  // Depends only on registered counters and decode, never on issue.
  logic hz_rs1, hz_rs2, hz_waw;
  assign hz_rs1 = sb.reg1_read    & ~zero_vec[rs1];
  assign hz_rs2 = sb.reg2_read    & ~zero_vec[rs2];
  assign hz_waw = sb.dec_regwrite &  full_vec[rd];

  assign sb.RAW_check = sb.processing & (hz_rs1 | hz_rs2 | hz_waw);

  logic idle_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      idle_q <= &next_zero_vec;
      err_q  <= err_q | (|err_vec);
    end
  end

  assign sb.idle = idle_q;
  assign sb.err  = err_q;

endmodule

// File: tb/tb_raw_scoreboard.sv
// Directed bench for raw_scoreboard: a table of per-cycle vectors with hand-computed
// outputs, plus a sweep over all registers for index decoding and drain.
module tb_raw_scoreboard;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  raw_scoreboard_if bus ();

  raw_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    bit       rst;
    bit       proc;
    bit       r1;
    bit [4:0] a1;
    bit       r2;
    bit [4:0] a2;
    bit       dw;
    bit [4:0] drd;
    bit       iss;
    bit       wbw;
    bit [4:0] wba;
    bit       exp_raw;
    bit       exp_idle;
    bit       exp_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, bit r, bit p, bit r1, bit [4:0] a1, bit r2,
                              bit [4:0] a2, bit dw, bit [4:0] drd, bit iss, bit wbw,
                              bit [4:0] wba, bit raw, bit idl, bit er);
    vec_t v;
    v.name = n; v.rst = r; v.proc = p; v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2;
    v.dw = dw; v.drd = drd; v.iss = iss; v.wbw = wbw; v.wba = wba;
    v.exp_raw = raw; v.exp_idle = idl; v.exp_err = er;
    return v;
  endfunction

  task automatic check(string nm, logic act, bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst              = v.rst;
    bus.processing   = v.proc;
    bus.reg1_read    = v.r1;
    bus.raddr1       = v.a1;
    bus.reg2_read    = v.r2;
    bus.raddr2       = v.a2;
    bus.dec_regwrite = v.dw;
    bus.dec_rd       = v.drd;
    bus.issue        = v.iss;
    bus.wb_regwrite  = v.wbw;
    bus.wb_addr      = v.wba;
  endtask

  task automatic idle_inputs();
    drive(mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          name         rst p  r1 a1  r2 a2  dw drd iss wbw wba  raw idle err
    vq.push_back(mk("t1_read5",   0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
    vq.push_back(mk("t2_iss5",    0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0,   0, 1, 0));
    vq.push_back(mk("t2_c1",      0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vq.push_back(mk("t2_c2",      0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    vq.push_back(mk("t2_c3wb",    0, 1, 1, 5, 0, 0, 0, 0, 0, 1, 5,   1, 0, 0));
    vq.push_back(mk("t2_c4",      0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
    vq.push_back(mk("t3_iss7",    0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0,   0, 1, 0));
    vq.push_back(mk("t3_isswb7",  0, 1, 0, 0, 0, 0, 1, 7, 1, 1, 7,   0, 0, 0));
    vq.push_back(mk("t3_rs2_7",   0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0,   1, 0, 0));
    vq.push_back(mk("t3_rs2_23wb",0, 1, 0, 0, 1, 23, 0, 0, 0, 1, 7,  1, 0, 0));
    vq.push_back(mk("t3_clear",   0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0,   0, 1, 0));
    vq.push_back(mk("t4_iss3a",   0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 1, 0));
    vq.push_back(mk("t4_iss3b",   0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 0, 0));
    vq.push_back(mk("t4_iss3c",   0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 0, 0));
    vq.push_back(mk("t4_wawfull", 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0,   1, 0, 0));
    vq.push_back(mk("t4_noproc",  0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 0, 0));
    vq.push_back(mk("t4_rd19wb",  0, 1, 0, 0, 0, 0, 1, 19, 0, 1, 3,  1, 0, 0));
    vq.push_back(mk("t4_notfull", 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 0, 0));
    vq.push_back(mk("t4_wb_a",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0));
    vq.push_back(mk("t4_wb_b",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0));
    vq.push_back(mk("t4_drained", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
    vq.push_back(mk("t5_iss0",    0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 1, 0));
    vq.push_back(mk("t5_x0_hi",   0, 1, 1, 0, 1, 16, 1, 16, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk("t5_wb0",     0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0));
    vq.push_back(mk("t5_after",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0));
    vq.push_back(mk("t6_iss12",   0, 1, 0, 0, 0, 0, 1, 12, 1, 0, 0,  0, 1, 0));
    vq.push_back(mk("t6_wb9",     0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 0));
    vq.push_back(mk("t6_errset",  0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1));
    vq.push_back(mk("t6_rstcyc",  1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1));
    vq.push_back(mk("t6_postrst", 0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
    vq.push_back(mk("t7_iss3a",   0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 1, 0));
    vq.push_back(mk("t7_iss3b",   0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 0, 0));
    vq.push_back(mk("t7_iss3c",   0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 0, 0));
    vq.push_back(mk("t7_ovf",     0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 0, 0));
    vq.push_back(mk("t7_sat",     0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0,   1, 0, 1));
    vq.push_back(mk("t7_wb_a",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 1));
    vq.push_back(mk("t7_wb_b",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 1));
    vq.push_back(mk("t7_wb_c",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 1));
    vq.push_back(mk("t7_drained", 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1));

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k]);
      #1;
      check({vq[k].name, ".RAW_check"}, bus.RAW_check, vq[k].exp_raw);
      check({vq[k].name, ".idle"},      bus.idle,      vq[k].exp_idle);
      check({vq[k].name, ".err"},       bus.err,       vq[k].exp_err);
    end

    // Sweep: fresh reset, one pending write on every register 1..15.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 16; i++) begin
      bus.dec_regwrite = 1'b1;
      bus.dec_rd       = 5'(i);
      bus.issue        = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("sweep.idle_busy", bus.idle, 1'b0);

    // Retire in order; each register clears while higher ones still hazard.
    for (int i = 1; i < 16; i++) begin
      bus.processing = 1'b1;
      bus.reg1_read  = 1'b1;
      bus.raddr1     = 5'(i);
      bus.reg2_read  = 1'b0;
      #1;
      check($sformatf("sweep.pend%0d", i), bus.RAW_check, 1'b1);
      bus.wb_regwrite = 1'b1;
      bus.wb_addr     = 5'(i);
      @(negedge clk);
      bus.wb_regwrite = 1'b0;
      bus.reg2_read   = (i < 15);
      bus.raddr2      = 5'(i + 1);
      bus.reg1_read   = 1'b0;
      #1;
      check($sformatf("sweep.next%0d", i), bus.RAW_check, (i < 15) ? 1'b1 : 1'b0);
      bus.reg2_read = 1'b0;
      bus.reg1_read = 1'b1;
      #1;
      check($sformatf("sweep.clr%0d", i), bus.RAW_check, 1'b0);
      check($sformatf("sweep.idle%0d", i), bus.idle, (i == 15) ? 1'b1 : 1'b0);
    end
    check("sweep.err", bus.err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
